// File: rtl/pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared types and constants for the pulse-train sequencer.
//   state_t     : FSM states of pulse_seq (IDLE, DELAY, PULSE, GAP)
//   DEF_*_W     : default field widths for the configuration inputs
//   max3()      : width of the shared timer (widest of the three timer fields)
// -----------------------------------------------------------------------------
package pulse_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int DEF_WIDTH_W = 8;
   localparam int DEF_COUNT_W = 8;
   localparam int DEF_SPACE_W = 16;
   localparam int DEF_DELAY_W = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/pulse_seq_timer.sv
// -----------------------------------------------------------------------------
// pulse_seq_timer
// Loadable down-counter shared by the DELAY, PULSE and GAP phases.
// The owner loads (length - 1) on entry to a phase and leaves the phase in
// the cycle where zero_o is high, so a phase lasts exactly "length" cycles.
// The counter saturates at zero and never wraps.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (count -> 0)
//   i_load     in   load i_load_val on the next edge (wins over i_dec)
//   i_dec      in   decrement by one on the next edge while non-zero
//   i_load_val in   CNT_W value to load
//   o_zero     out  count is zero
// -----------------------------------------------------------------------------
module pulse_seq_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && !o_zero) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_seq.sv
// -----------------------------------------------------------------------------
// pulse_seq
// Generates a train of N pulses, each W cycles active, separated by S
// inactive cycles, starting D cycles after a start request is accepted.
// D, W, N, S and the polarity are captured when the request is accepted, so
// the inputs may be rewritten while a train is running.
// Optional feature: define PULSE_SEQ_ABORT_EN to add abort_i, which returns a
// running train to IDLE on the next edge without a done_o strobe.
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   en               in   start request (taken when ready_o=1)
//   abort_i          in   (PULSE_SEQ_ABORT_EN only) abandon the current train
//   delay_i          in   cycles from acceptance to first pulse (D)
//   pulse_width_i    in   active cycles per pulse (W)
//   num_pulses_i     in   pulses per train (N)
//   pulse_spacing_i  in   inactive cycles between pulses (S)
//   invert_i         in   1 = active-low output
//   pulse_o          out  registered pulse output
//   ready_o          out  idle, start request can be taken
//   done_o           out  one-cycle strobe when a train completes
// -----------------------------------------------------------------------------
module pulse_seq
   import pulse_seq_pkg::*;
#(
   parameter int WIDTH_W = DEF_WIDTH_W,
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int SPACE_W = DEF_SPACE_W,
   parameter int DELAY_W = DEF_DELAY_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
`ifdef PULSE_SEQ_ABORT_EN
   input  logic               abort_i,
`endif
   input  logic [DELAY_W-1:0] delay_i,
   input  logic [WIDTH_W-1:0] pulse_width_i,
   input  logic [COUNT_W-1:0] num_pulses_i,
   input  logic [SPACE_W-1:0] pulse_spacing_i,
   input  logic               invert_i,
   output logic               pulse_o,
   output logic               ready_o,
   output logic               done_o
);

   localparam int TMR_W = max3(WIDTH_W, SPACE_W, DELAY_W);

   state_t             r_state;
   logic [WIDTH_W-1:0] r_width;
   logic [SPACE_W-1:0] r_space;
   logic [COUNT_W-1:0] r_cnt;     // pulses still to be emitted, current one included
   logic               r_inv;
   logic               r_pulse;
   logic               r_done;

   state_t             w_state_next;
   logic [COUNT_W-1:0] w_cnt_next;
   logic               w_tmr_load;
   logic [TMR_W-1:0]   w_tmr_val;
   logic               w_tmr_zero;
   logic               w_active_next;
   logic               w_done_next;
   logic               w_latch;
   logic               w_inv_next;

   pulse_seq_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_dec      (r_state != IDLE),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_tmr_load    = 1'b0;
      w_tmr_val     = '0;
      w_active_next = 1'b0;
      w_done_next   = 1'b0;
      w_latch       = 1'b0;

      case (r_state)
         IDLE: begin
            if (en) begin
               w_latch    = 1'b1;
               w_cnt_next = num_pulses_i;
               if (num_pulses_i == '0 || pulse_width_i == '0) begin
                  // Empty train: finish immediately, stay idle.
                  w_done_next = 1'b1;
               end else if (delay_i == '0) begin
                  w_state_next  = PULSE;
                  w_tmr_load    = 1'b1;
                  w_tmr_val     = TMR_W'(pulse_width_i) - TMR_W'(1);
                  w_active_next = 1'b1;
               end else begin
                  w_state_next = DELAY;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = TMR_W'(delay_i) - TMR_W'(1);
               end
            end
         end

         DELAY: begin
            if (w_tmr_zero) begin
               w_state_next  = PULSE;
               w_tmr_load    = 1'b1;
               w_tmr_val     = TMR_W'(r_width) - TMR_W'(1);
               w_active_next = 1'b1;
            end
         end

         PULSE: begin
            if (w_tmr_zero) begin
               if (r_cnt == COUNT_W'(1)) begin
                  // Last pulse: no trailing gap.
                  w_state_next = IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_cnt_next = r_cnt - COUNT_W'(1);
                  w_tmr_load = 1'b1;
                  if (r_space == '0) begin
                     // Zero spacing: pulses run back to back as one active period.
                     w_tmr_val     = TMR_W'(r_width) - TMR_W'(1);
                     w_active_next = 1'b1;
                  end else begin
                     w_state_next = GAP;
                     w_tmr_val    = TMR_W'(r_space) - TMR_W'(1);
                  end
               end
            end else begin
               w_active_next = 1'b1;
            end
         end

         GAP: begin
            if (w_tmr_zero) begin
               w_state_next  = PULSE;
               w_tmr_load    = 1'b1;
               w_tmr_val     = TMR_W'(r_width) - TMR_W'(1);
               w_active_next = 1'b1;
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase

`ifdef PULSE_SEQ_ABORT_EN
      // Abort only matters while busy; en is never taken outside IDLE anyway.
      if (abort_i && r_state != IDLE) begin
         w_state_next  = IDLE;
         w_tmr_load    = 1'b0;
         w_active_next = 1'b0;
         w_done_next   = 1'b0;
         w_cnt_next    = r_cnt;
      end
`endif
   end

   // Polarity takes effect together with the train that latched it.
   assign w_inv_next = w_latch ? invert_i : r_inv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_width <= '0;
         r_space <= '0;
         r_cnt   <= '0;
         r_inv   <= 1'b0;
         r_pulse <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_inv   <= w_inv_next;
         r_pulse <= w_active_next ^ w_inv_next;
         r_done  <= w_done_next;
         if (w_latch) begin
            r_width <= pulse_width_i;
            r_space <= pulse_spacing_i;
         end
      end
   end

   assign pulse_o = r_pulse;
   assign ready_o = (r_state == IDLE);
   assign done_o  = r_done;

endmodule

// File: tb/tb_pulse_seq.sv
// -----------------------------------------------------------------------------
// tb_pulse_seq
// Self-checking bench for pulse_seq. A cycle-level reference model computes
// expected pulse_o/ready_o/done_o from the train arithmetic (acceptance cycle,
// D, W, N, S); a table of directed trains checks latency and active-cycle
// counts; hand sequences cover busy/back-to-back/reset (and abort when
// PULSE_SEQ_ABORT_EN is defined); a random phase exercises everything.
// Cycle c below means the interval just after rising edge number c.
// -----------------------------------------------------------------------------
module tb_pulse_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] delay_i;
   logic [7:0]  pulse_width_i;
   logic [7:0]  num_pulses_i;
   logic [15:0] pulse_spacing_i;
   logic        invert_i;
   logic        pulse_o;
   logic        ready_o;
   logic        done_o;
`ifdef PULSE_SEQ_ABORT_EN
   logic        abort_i;
`endif

   always #5 clk = ~clk;

   pulse_seq dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
`ifdef PULSE_SEQ_ABORT_EN
      .abort_i         (abort_i),
`endif
      .delay_i         (delay_i),
      .pulse_width_i   (pulse_width_i),
      .num_pulses_i    (num_pulses_i),
      .pulse_spacing_i (pulse_spacing_i),
      .invert_i        (invert_i),
      .pulse_o         (pulse_o),
      .ready_o         (ready_o),
      .done_o          (done_o)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int cyc = 0;
   bit m_valid = 1'b0;
   bit m_busy  = 1'b0;
   bit m_inv   = 1'b0;
   int m_k, m_end, m_d, m_w, m_n, m_s;
   bit e_pulse = 1'b0, e_ready = 1'b1, e_done = 1'b0;

   // Is the train active in cycle t? Offset o from the first active cycle;
   // each period of W+S cycles starts with W active ones.
   function automatic bit m_active(input int t);
      int o;
      if (m_n == 0 || m_w == 0) return 1'b0;
      o = t - m_k - m_d;
      if (o < 0 || o >= m_n * m_w + (m_n - 1) * m_s) return 1'b0;
      return (o % (m_w + m_s)) < m_w;
   endfunction

   task automatic model_edge();
      cyc++;
      if (rst) begin
         m_valid = 1'b1; m_busy = 1'b0; m_inv = 1'b0;
         e_pulse = 1'b0; e_ready = 1'b1; e_done = 1'b0;
         return;
      end
      if (!m_valid) return;
`ifdef PULSE_SEQ_ABORT_EN
      if (abort_i && !e_ready) begin
         m_busy = 1'b0;
         e_pulse = m_inv; e_ready = 1'b1; e_done = 1'b0;
         return;
      end
`endif
      if (en && e_ready) begin
         m_k = cyc;
         m_d = int'(delay_i); m_w = int'(pulse_width_i);
         m_n = int'(num_pulses_i); m_s = int'(pulse_spacing_i);
         m_inv = invert_i;
         m_busy = 1'b1;
         if (m_n == 0 || m_w == 0) m_end = cyc;
         else m_end = cyc + m_d + m_n * m_w + (m_n - 1) * m_s;
      end
      if (m_busy) begin
         if (cyc == m_end) begin
            e_done = 1'b1; e_ready = 1'b1; e_pulse = m_inv; m_busy = 1'b0;
         end else begin
            e_done = 1'b0; e_ready = 1'b0; e_pulse = m_active(cyc) ^ m_inv;
         end
      end else begin
         e_done = 1'b0; e_ready = 1'b1; e_pulse = m_inv;
      end
   endtask

   // One clock: model update at the edge, DUT compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (m_valid) begin
         checks++;
         if ({pulse_o, ready_o, done_o} !== {e_pulse, e_ready, e_done}) begin
            errors++;
            $display("FAIL model cycle %0d: pulse/ready/done got %b%b%b required %b%b%b",
                     cyc, pulse_o, ready_o, done_o, e_pulse, e_ready, e_done);
         end
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic set_cfg(input int d, input int w, input int n, input int s, input bit inv);
      delay_i = 16'(d); pulse_width_i = 8'(w); num_pulses_i = 8'(n);
      pulse_spacing_i = 16'(s); invert_i = inv;
   endtask

   // Start a train and run it to done_o. lat = cycles from acceptance cycle
   // to the done cycle, act = active cycles seen. disturb >= 0 raises en with
   // a different config at that cycle offset (must be ignored).
   task automatic run_train(input int d, input int w, input int n, input int s, input bit inv,
                            input int disturb, output int lat, output int act);
      set_cfg(d, w, n, s, inv);
      en = 1'b1;
      lat = -1; act = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) begin
            if (i == disturb) begin
               en = 1'b1; set_cfg(0, 1, 1, 0, !inv);
            end else begin
               en = 1'b0;
            end
         end
         step();
         if (i == 0) en = 1'b0;
         if (pulse_o ^ inv) act++;
         if (done_o) begin
            lat = i;
            break;
         end
      end
      en = 1'b0;
   endtask

   typedef struct {
      int d; int w; int n; int s; bit inv;
      int lat; int act;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int lat, act, cd, first, trains;
      string nm;

      vecs[0] = '{d: 5,   w: 3,   n: 4, s: 2, inv: 1'b0, lat: 23,  act: 12};
      vecs[1] = '{d: 0,   w: 4,   n: 3, s: 0, inv: 1'b0, lat: 12,  act: 12};
      vecs[2] = '{d: 3,   w: 2,   n: 0, s: 1, inv: 1'b0, lat: 0,   act: 0};
      vecs[3] = '{d: 2,   w: 0,   n: 3, s: 1, inv: 1'b0, lat: 0,   act: 0};
      vecs[4] = '{d: 1,   w: 1,   n: 1, s: 0, inv: 1'b1, lat: 2,   act: 1};
      vecs[5] = '{d: 0,   w: 1,   n: 5, s: 1, inv: 1'b1, lat: 9,   act: 5};
      vecs[6] = '{d: 2,   w: 5,   n: 2, s: 3, inv: 1'b0, lat: 15,  act: 10};
      vecs[7] = '{d: 0,   w: 255, n: 1, s: 0, inv: 1'b0, lat: 255, act: 255};
      vecs[8] = '{d: 300, w: 1,   n: 1, s: 0, inv: 1'b1, lat: 301, act: 1};

      rst = 1'b1; en = 1'b0;
      set_cfg(0, 0, 0, 0, 1'b0);
`ifdef PULSE_SEQ_ABORT_EN
      abort_i = 1'b0;
`endif

      // Reset then idle.
      repeat (3) step();
      chk("reset ready_o", int'(ready_o), 1);
      chk("reset pulse_o", int'(pulse_o), 0);
      chk("reset done_o", int'(done_o), 0);
      rst = 1'b0;
      step();

      // Directed table.
      foreach (vecs[i]) begin
         run_train(vecs[i].d, vecs[i].w, vecs[i].n, vecs[i].s, vecs[i].inv, -1, lat, act);
         $display("train %0d: D=%0d W=%0d N=%0d S=%0d inv=%0d lat=%0d act=%0d",
                  i, vecs[i].d, vecs[i].w, vecs[i].n, vecs[i].s, vecs[i].inv, lat, act);
         nm = $sformatf("vec%0d latency", i);
         chk(nm, lat, vecs[i].lat);
         nm = $sformatf("vec%0d active cycles", i);
         chk(nm, act, vecs[i].act);
         step();
      end
      // Last train was inverted: idle level must stay high.
      chk("idle level after inverted train", int'(pulse_o), 1);

      // en and config changes while busy are ignored.
      run_train(5, 3, 4, 2, 1'b0, 8, lat, act);
      $display("busy-en train: lat=%0d act=%0d", lat, act);
      chk("busy en latency", lat, 23);
      chk("busy en active cycles", act, 12);
      step();

      // en held high: second train accepted in the done cycle.
      set_cfg(2, 2, 2, 1, 1'b0);
      en = 1'b1;
      cd = -1; first = -1;
      for (int i = 0; i < 200 && first < 0; i++) begin
         step();
         if (cd < 0 && done_o) cd = cyc;
         else if (cd >= 0 && pulse_o) first = cyc;
      end
      en = 1'b0;
      $display("back-to-back: done cycle %0d, next first pulse %0d", cd, first);
      chk("back-to-back second pulse offset", first - cd, 3);
      for (int i = 0; i < 20; i++) step();

      // Reset during PULSE.
      run_train(0, 5, 1, 0, 1'b1, -1, lat, act);
      step();
      set_cfg(0, 5, 1, 0, 1'b0);
      en = 1'b1; step(); en = 1'b0;
      step();
      chk("pulse active before reset", int'(pulse_o), 1);
      rst = 1'b1; step(); rst = 1'b0;
      $display("reset mid-pulse: pulse=%0d ready=%0d done=%0d", pulse_o, ready_o, done_o);
      chk("reset mid-train pulse_o", int'(pulse_o), 0);
      chk("reset mid-train ready_o", int'(ready_o), 1);
      chk("reset mid-train done_o", int'(done_o), 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("no done after reset abort", int'(done_o), 0);
      end

`ifdef PULSE_SEQ_ABORT_EN
      // Abort during GAP (D=1, W=2: gap begins 3 cycles after acceptance).
      set_cfg(1, 2, 3, 4, 1'b0);
      en = 1'b1; step(); en = 1'b0;
      repeat (3) step();
      chk("in gap before abort ready_o", int'(ready_o), 0);
      abort_i = 1'b1; step(); abort_i = 1'b0;
      $display("abort in gap: pulse=%0d ready=%0d done=%0d", pulse_o, ready_o, done_o);
      chk("abort ready_o", int'(ready_o), 1);
      chk("abort done_o", int'(done_o), 0);
      chk("abort pulse_o", int'(pulse_o), 0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("no pulse after abort", int'(pulse_o), 0);
      end
`endif

      // Random phase against the model.
      trains = 0;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) == 0);
         set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         rst = ($urandom_range(0, 249) == 0);
`ifdef PULSE_SEQ_ABORT_EN
         abort_i = ($urandom_range(0, 39) == 0);
`endif
         step();
         if (done_o) trains++;
      end
      rst = 1'b0; en = 1'b0;
`ifdef PULSE_SEQ_ABORT_EN
      abort_i = 1'b0;
`endif
      $display("random phase: %0d trains completed", trains);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
